// File: rtl/core_pkg.sv
// Shared defaults and FSM encoding for the decode-stage register file.
package core_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_NUM_REGS = 16;
  localparam int unsigned DEF_ADDR_W   = 4;
  localparam int unsigned DEF_PC_REG   = 15;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits for load-use hazard detection; the PC entry never goes pending.
module reg_scoreboard
  import core_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned PC_REG   = DEF_PC_REG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_valid,
  input  logic [ADDR_W-1:0] set_dst,
  input  logic              clr_valid,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic              pend1,
  output logic              pend2
);

  logic [NUM_REGS-1:0] pending_q, pending_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // A same-cycle set beats a clear: the newer producer is still in flight.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i == PC_REG) begin
        pending_d[i] = 1'b0;
      end else if (set_valid && set_dst == ADDR_W'(i)) begin
        pending_d[i] = 1'b1;
      end else if (clr_valid && clr_addr == ADDR_W'(i)) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  // A completing producer is hidden by the write bypass unless a new one issues.
  always_comb begin
    pend1 = pending_q[ra1] &
            ~(clr_valid && clr_addr == ra1 && !(set_valid && set_dst == ra1));
    pend2 = pending_q[ra2] &
            ~(clr_valid && clr_addr == ra2 && !(set_valid && set_dst == ra2));
  end

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/two-write register file with write bypass, PC substitution, scrub-on-reset
// and a pending scoreboard.
module reg_file_sb
  import core_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned PC_REG   = DEF_PC_REG
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic [DATA_W-1:0] R15,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] WA3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              WE4,
  input  logic [ADDR_W-1:0] WA4,
  input  logic [DATA_W-1:0] WD4,
  input  logic              ISSUE_VALID,
  input  logic [ADDR_W-1:0] ISSUE_DST,
  output logic              PEND1,
  output logic              PEND2,
  output logic              READY
);

  localparam logic [ADDR_W-1:0] PcAddr    = ADDR_W'(PC_REG);
  localparam logic [ADDR_W-1:0] LastScrub = ADDR_W'(NUM_REGS - 2);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              run;
  logic              we3_ok, we4_ok;
  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rd [2];

  assign run    = (state_q == RUN);
  assign READY  = run;
  assign we3_ok = run && WE3 && (WA3 != PcAddr);
  assign we4_ok = run && WE4 && (WA4 != PcAddr);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter parks on the last scrubbed entry, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        if (cnt_q == LastScrub) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // WE3 is applied last so it wins a same-address collision with WE4.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (!run) begin
        mem_q[cnt_q] <= '0;
      end else begin
        if (we4_ok) mem_q[WA4] <= WD4;
        if (we3_ok) mem_q[WA3] <= WD3;
      end
    end
  end

  assign ra[0] = RA1;
  assign ra[1] = RA2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p] = '0;
      if (!run) begin
        rd[p] = '0;
      end else if (ra[p] == PcAddr) begin
        rd[p] = R15;
      end else if (WE3 && WA3 == ra[p]) begin
        rd[p] = WD3;
      end else if (WE4 && WA4 == ra[p]) begin
        rd[p] = WD4;
      end else begin
        rd[p] = mem_q[ra[p]];
      end
    end
  end

  assign RD1 = rd[0];
  assign RD2 = rd[1];

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .PC_REG   (PC_REG)
  ) u_scoreboard (
    .clk       (CLK),
    .reset     (RESET),
    .set_valid (run && ISSUE_VALID),
    .set_dst   (ISSUE_DST),
    .clr_valid (we3_ok),
    .clr_addr  (WA3),
    .ra1       (RA1),
    .ra2       (RA2),
    .pend1     (PEND1),
    .pend2     (PEND2)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: scrub, bypass, PC handling and scoreboard cases.
module tb_reg_file_sb;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  RA1, RA2, WA3, WA4, ISSUE_DST;
  logic [31:0] RD1, RD2, R15, WD3, WD4;
  logic        WE3, WE4, ISSUE_VALID;
  logic        PEND1, PEND2, READY;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  reg_file_sb dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .RA1         (RA1),
    .RA2         (RA2),
    .RD1         (RD1),
    .RD2         (RD2),
    .R15         (R15),
    .WE3         (WE3),
    .WA3         (WA3),
    .WD3         (WD3),
    .WE4         (WE4),
    .WA4         (WA4),
    .WD4         (WD4),
    .ISSUE_VALID (ISSUE_VALID),
    .ISSUE_DST   (ISSUE_DST),
    .PEND1       (PEND1),
    .PEND2       (PEND2),
    .READY       (READY)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    WE3 = 0; WA3 = 0; WD3 = 0;
    WE4 = 0; WA4 = 0; WD4 = 0;
    ISSUE_VALID = 0; ISSUE_DST = 0;
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 40 && READY !== 1'b1; i++) tick();
    n_cmp++;
    if (READY !== 1'b1) begin
      n_err++;
      $display("FAIL %s_ready_timeout got %b want 1", name, READY);
    end
  endtask

  task automatic test_reset();
    RESET = 1; idle(); RA1 = 0; RA2 = 0; R15 = 32'h0;
    tick();
    RESET = 0;
    wait_ready("initial");
    // Preload R3 and leave R9 pending, then reset from RUN.
    WE3 = 1; WA3 = 3; WD3 = 32'hDEAD; ISSUE_VALID = 1; ISSUE_DST = 9;
    tick(); idle();
    RA1 = 3;
    #1;
    n_cmp++;
    if (RD1 !== 32'hDEAD) begin
      n_err++; $display("FAIL preload_r3 got %h want %h", RD1, 32'hDEAD);
    end
    RESET = 1;
    tick();
    RESET = 0;
    for (int i = 0; i < 15; i++) begin
      if (i == 14) begin
        // Last INIT cycle: writes/issues here would survive if not ignored.
        WE3 = 1; WA3 = 2; WD3 = 32'h55; WE4 = 1; WA4 = 6; WD4 = 32'h66;
        ISSUE_VALID = 1; ISSUE_DST = 2;
        RA1 = 15; R15 = 32'h108; RA2 = 2;
        #1;
        n_cmp++;
        if (RD1 !== 32'h0) begin
          n_err++; $display("FAIL init_pc_read got %h want 0", RD1);
        end
        n_cmp++;
        if (RD2 !== 32'h0) begin
          n_err++; $display("FAIL init_bypass_read got %h want 0", RD2);
        end
      end
      n_cmp++;
      if (READY !== 1'b0) begin
        n_err++; $display("FAIL scrub_ready_low cycle %0d got %b want 0", i, READY);
      end
      tick();
    end
    idle();
    n_cmp++;
    if (READY !== 1'b1) begin
      n_err++; $display("FAIL scrub_ready_high got %b want 1", READY);
    end
    RA1 = 3; RA2 = 2;
    #1;
    n_cmp++;
    if (RD1 !== 32'h0) begin
      n_err++; $display("FAIL scrub_r3 got %h want 0", RD1);
    end
    n_cmp++;
    if (RD2 !== 32'h0) begin
      n_err++; $display("FAIL init_write_dropped got %h want 0", RD2);
    end
    n_cmp++;
    if (PEND2 !== 1'b0) begin
      n_err++; $display("FAIL init_issue_dropped got %b want 0", PEND2);
    end
    RA1 = 9; RA2 = 6;
    #1;
    n_cmp++;
    if (PEND1 !== 1'b0) begin
      n_err++; $display("FAIL reset_clears_pending got %b want 0", PEND1);
    end
    n_cmp++;
    if (RD2 !== 32'h0) begin
      n_err++; $display("FAIL init_we4_dropped got %h want 0", RD2);
    end
  endtask

  task automatic test_bypass();
    WE3 = 1; WA3 = 5; WD3 = 32'h11; WE4 = 1; WA4 = 5; WD4 = 32'h22;
    RA1 = 5; RA2 = 5;
    #1;
    n_cmp++;
    if (RD1 !== 32'h11) begin
      n_err++; $display("FAIL bypass_prio got %h want %h", RD1, 32'h11);
    end
    tick(); idle();
    n_cmp++;
    if (RD1 !== 32'h11) begin
      n_err++; $display("FAIL collision_store got %h want %h", RD1, 32'h11);
    end
    WE4 = 1; WA4 = 6; WD4 = 32'h22; RA2 = 6;
    #1;
    n_cmp++;
    if (RD2 !== 32'h22) begin
      n_err++; $display("FAIL bypass_we4 got %h want %h", RD2, 32'h22);
    end
    tick(); idle();
    n_cmp++;
    if (RD2 !== 32'h22) begin
      n_err++; $display("FAIL store_we4 got %h want %h", RD2, 32'h22);
    end
    // Back-to-back: both ports on distinct addresses, then read both.
    WE3 = 1; WA3 = 8; WD3 = 32'hA8; WE4 = 1; WA4 = 1; WD4 = 32'hB1;
    tick(); idle();
    RA1 = 8; RA2 = 1;
    #1;
    n_cmp++;
    if (RD1 !== 32'hA8 || RD2 !== 32'hB1) begin
      n_err++; $display("FAIL dual_write got %h/%h want a8/b1", RD1, RD2);
    end
  endtask

  task automatic test_pc();
    R15 = 32'h108; WE3 = 1; WA3 = 15; WD3 = 32'hFF; RA2 = 15;
    ISSUE_VALID = 1; ISSUE_DST = 15;
    #1;
    n_cmp++;
    if (RD2 !== 32'h108) begin
      n_err++; $display("FAIL pc_read_same got %h want %h", RD2, 32'h108);
    end
    tick(); idle();
    n_cmp++;
    if (RD2 !== 32'h108) begin
      n_err++; $display("FAIL pc_read_next got %h want %h", RD2, 32'h108);
    end
    n_cmp++;
    if (PEND2 !== 1'b0) begin
      n_err++; $display("FAIL pc_never_pending got %b want 0", PEND2);
    end
  endtask

  task automatic test_scoreboard();
    ISSUE_VALID = 1; ISSUE_DST = 7; RA1 = 7;
    #1;
    n_cmp++;
    if (PEND1 !== 1'b0) begin
      n_err++; $display("FAIL sb_not_yet got %b want 0", PEND1);
    end
    tick(); idle();
    n_cmp++;
    if (PEND1 !== 1'b1) begin
      n_err++; $display("FAIL sb_set got %b want 1", PEND1);
    end
    WE3 = 1; WA3 = 7; WD3 = 32'h77;
    #1;
    n_cmp++;
    if (PEND1 !== 1'b0 || RD1 !== 32'h77) begin
      n_err++; $display("FAIL sb_complete got %b/%h want 0/77", PEND1, RD1);
    end
    tick(); idle();
    n_cmp++;
    if (PEND1 !== 1'b0) begin
      n_err++; $display("FAIL sb_cleared got %b want 0", PEND1);
    end
    ISSUE_VALID = 1; ISSUE_DST = 10; RA1 = 10;
    tick(); idle();
    WE4 = 1; WA4 = 10; WD4 = 32'hAA;
    tick(); idle();
    n_cmp++;
    if (PEND1 !== 1'b1) begin
      n_err++; $display("FAIL sb_we4_no_clear got %b want 1", PEND1);
    end
    WE3 = 1; WA3 = 10; WD3 = 32'h1;
    tick(); idle();
  endtask

  task automatic test_collision();
    ISSUE_VALID = 1; ISSUE_DST = 4; RA1 = 4;
    tick(); idle();
    ISSUE_VALID = 1; ISSUE_DST = 4; WE3 = 1; WA3 = 4; WD3 = 32'h44;
    #1;
    n_cmp++;
    if (PEND1 !== 1'b1) begin
      n_err++; $display("FAIL coll_same_cycle got %b want 1", PEND1);
    end
    tick(); idle();
    n_cmp++;
    if (PEND1 !== 1'b1 || RD1 !== 32'h44) begin
      n_err++; $display("FAIL coll_set_wins got %b/%h want 1/44", PEND1, RD1);
    end
  endtask

  task automatic test_mid_scrub();
    RESET = 1;
    tick();
    RESET = 0;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (READY !== 1'b0) begin
        n_err++; $display("FAIL mid_first_low cycle %0d got %b want 0", i, READY);
      end
      tick();
    end
    RESET = 1;
    tick();
    RESET = 0;
    for (int i = 0; i < 15; i++) begin
      n_cmp++;
      if (READY !== 1'b0) begin
        n_err++; $display("FAIL mid_restart_low cycle %0d got %b want 0", i, READY);
      end
      tick();
    end
    n_cmp++;
    if (READY !== 1'b1) begin
      n_err++; $display("FAIL mid_restart_high got %b want 1", READY);
    end
    RA1 = 4;
    #1;
    n_cmp++;
    if (PEND1 !== 1'b0 || RD1 !== 32'h0) begin
      n_err++; $display("FAIL mid_state_clear got %b/%h want 0/0", PEND1, RD1);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_pc();
    test_scoreboard();
    test_collision();
    test_mid_scrub();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the core's 3-port register file: general-purpose register array with two read ports, two write ports (result writeback plus base-register writeback for pre/post-indexed LDR/STR), internal write-to-read bypass, and a per-register pending scoreboard for load-use hazard detection.
- After reset, a scrub sequencer clears the array one entry per cycle and then raises READY.
- Sits in the decode stage. The PC value is supplied externally on R15 and is never stored.

Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 16, architectural register count, PC included
- ADDR_W, 4, address width; must equal $clog2(NUM_REGS)
- PC_REG, 15, index that reads from R15 and is never written or marked pending

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- RA1  in  ADDR_W  read port 1 address
- RA2  in  ADDR_W  read port 2 address
- RD1  out  DATA_W  read port 1 data, combinational
- RD2  out  DATA_W  read port 2 data, combinational
- R15  in  DATA_W  current PC+8 value, returned when a read address is PC_REG
- WE3  in  1  result write enable
- WA3  in  ADDR_W  result write address
- WD3  in  DATA_W  result write data
- WE4  in  1  base-writeback write enable
- WA4  in  ADDR_W  base-writeback address
- WD4  in  DATA_W  base-writeback data
- ISSUE_VALID  in  1  an instruction with a register destination issues this cycle
- ISSUE_DST  in  ADDR_W  destination register of the issuing instruction
- PEND1  out  1  RA1 has an outstanding producer
- PEND2  out  1  RA2 has an outstanding producer
- READY  out  1  scrub complete; block is accepting traffic

Behaviour:
- FSM states are INIT and RUN.
- RESET high at any cycle, including mid-scrub or mid-operation:
  - next state is INIT
  - scrub counter is 0
  - all pending bits are cleared
- INIT:
  - each cycle writes 0 to entry[counter], then increments counter.
  - after entry NUM_REGS-2 is written, state goes to RUN. The scrub takes NUM_REGS-1 cycles; READY rises on the following cycle.
- While in INIT:
  - READY=0
  - RD1=RD2=0, including for PC_REG
  - PEND1=PEND2=0
  - WE3, WE4 and ISSUE_VALID are ignored
- RUN: READY=1.
- Write rules:
  - write on the rising edge when the enable is high and the address is not PC_REG; writes to PC_REG are dropped silently.
  - WE3 and WE4 to the same address in the same cycle: WD3 is stored and WD4 is dropped.
- Read priority, highest first, for each port:
  1. address == PC_REG returns R15.
  2. WE3 && WA3 == RAx returns WD3 (same-cycle bypass).
  3. WE4 && WA4 == RAx returns WD4.
  4. otherwise the array entry.
  Read latency is zero (combinational).
- Scoreboard (one bit per register, bit PC_REG tied 0):
  - set on ISSUE_VALID for ISSUE_DST
  - cleared when a WE3 write to that address is accepted
  - WE4 does not clear pending bits
  - set and clear on the same address in the same cycle: set wins, since a newer producer is in flight
  - PENDx = pending[RAx] & ~(WE3 && WA3 == RAx && no same-cycle set on RAx); the bypass hides a completing producer.
- No arithmetic beyond the scrub counter. The counter is ADDR_W bits wide and never wraps, because it stops at NUM_REGS-2.

Decomposition:
- Shared package core_pkg:
  - DATA_W and ADDR_W defaults
  - PC_REG index
  - FSM state encoding {INIT=0, RUN=1}
- One sub-module is natural: reg_scoreboard, which holds the pending bit vector, the set/clear priority, and the PEND1/PEND2 lookup. Array, bypass and FSM stay in the top.

Test Plan:
- Reset scrub:
  - stimulus: pre-load R3=0xDEAD through WE3, then assert RESET 1 cycle.
  - required: READY=0 for 15 cycles, then 1; RA1=3 reads 0; writes attempted during INIT have no effect.
- Bypass and priority:
  - stimulus: WE3 WA3=5 WD3=0x11 and WE4 WA4=5 WD4=0x22 in the same cycle with RA1=5.
  - required: RD1=0x11 that cycle; next cycle RD1=0x11.
- PC handling:
  - stimulus: R15=0x108, WE3 WA3=15 WD3=0xFF, RA2=15.
  - required: RD2=0x108 both cycles; PEND2=0 after ISSUE_DST=15.
- Scoreboard:
  - stimulus: ISSUE_VALID ISSUE_DST=7.
  - required: next cycle PEND1=1 for RA1=7. In the cycle WE3 WA3=7 is high, PEND1=0 and RD1=WD3; afterwards pending is clear.
- Set/clear collision:
  - stimulus: pending[4]=1, then in one cycle ISSUE_DST=4 with WE3 WA3=4.
  - required: next cycle PEND1(RA1=4)=1; data equals the written value.
- Reset mid-scrub:
  - stimulus: assert RESET at scrub cycle 6.
  - required: counter restarts; READY rises exactly 15 cycles after the second RESET deassertion.
